// File: rtl/gray_pkg.sv
// gray_pkg: shared Gray-code helper and terminal-value constants
package gray_pkg;
    localparam int GRAY_WIDTH = 4;
    localparam int MAX_WIDTH = 32;
    localparam logic [MAX_WIDTH-1:0] ALL_ONES = '1;
    localparam logic [MAX_WIDTH-1:0] ALL_ZERO = '0;
    function automatic logic [MAX_WIDTH-1:0] bin2gray_f(input logic [MAX_WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction
endpackage

// File: rtl/gray_counter_if.sv
// gray_counter_if: control inputs and count outputs of the Gray counter
interface gray_counter_if import gray_pkg::*; #(parameter int WIDTH = GRAY_WIDTH);
    logic             en;
    logic             up;
    logic             load;
    logic [WIDTH-1:0] load_bin;
    logic [WIDTH-1:0] bin;
    logic [WIDTH-1:0] gray;
    logic             tc;
    modport master (output en, up, load, load_bin, input bin, gray, tc);
    modport slave (input en, up, load, load_bin, output bin, gray, tc);
endinterface

// File: rtl/bin2gray.sv
// bin2gray: combinational binary to Gray-code converter
module bin2gray import gray_pkg::*; #(
    parameter int WIDTH = GRAY_WIDTH
) (
    input  logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray
);
    assign gray = WIDTH'(bin2gray_f(MAX_WIDTH'(bin)));
endmodule

// File: rtl/gray_counter.sv
// gray_counter: registered up/down counter with binary and Gray outputs
module gray_counter import gray_pkg::*; #(
    parameter int WIDTH = GRAY_WIDTH,
    parameter bit WRAP  = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    gray_counter_if.slave bus
);
    localparam logic [WIDTH-1:0] MAX_V  = WIDTH'(ALL_ONES);
    localparam logic [WIDTH-1:0] ZERO_V = WIDTH'(ALL_ZERO);
    logic [WIDTH-1:0] step, nxt, nxt_gray;
    logic at_term, nxt_tc;
    // next binary value by priority load > en > hold; terminal steps wrap or hold
    always_comb begin
        at_term = bus.up ? (bus.bin == MAX_V) : (bus.bin == ZERO_V);
        step    = bus.up ? bus.bin + WIDTH'(1) : bus.bin - WIDTH'(1);
        nxt     = bus.load ? bus.load_bin : (bus.en && !(at_term && !WRAP)) ? step : bus.bin;
        nxt_tc  = bus.en && !bus.load && at_term;
    end
    // Gray is derived from the next binary value so both registers update together
    bin2gray #(.WIDTH(WIDTH)) u_b2g (.bin(nxt), .gray(nxt_gray));
    // output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.bin  <= '0;
            bus.gray <= '0;
            bus.tc   <= 1'b0;
        end else begin
            bus.bin  <= nxt;
            bus.gray <= nxt_gray;
            bus.tc   <= nxt_tc;
        end
    end
endmodule

// File: tb/tb_gray_counter.sv
// tb_gray_counter: directed and random checks of wrap and saturate counters
module tb_gray_counter;
    logic clk = 1'b0, rst = 1'b1, en = 1'b0, up = 1'b1, load = 1'b0;
    logic [3:0] load_bin = 4'd0;
    int tests = 0, fails = 0;

    gray_counter_if #(.WIDTH(4)) wif ();
    gray_counter_if #(.WIDTH(4)) sif ();
    assign wif.en = en;
    assign wif.up = up;
    assign wif.load = load;
    assign wif.load_bin = load_bin;
    assign sif.en = en;
    assign sif.up = up;
    assign sif.load = load;
    assign sif.load_bin = load_bin;

    gray_counter #(.WIDTH(4), .WRAP(1'b1)) u_wrap (.clk(clk), .rst(rst), .bus(wif));
    gray_counter #(.WIDTH(4), .WRAP(1'b0)) u_sat (.clk(clk), .rst(rst), .bus(sif));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; load = 1'b0;
        tick(); tick();
        tests++; if (wif.bin !== 4'd0) begin fails++; $display("FAIL reset_bin: got %0d want 0", wif.bin); end
        tests++; if (wif.gray !== 4'd0) begin fails++; $display("FAIL reset_gray: got %0d want 0", wif.gray); end
        tests++; if (wif.tc !== 1'b0) begin fails++; $display("FAIL reset_tc: got %0b want 0", wif.tc); end
        tests++; if (sif.bin !== 4'd0) begin fails++; $display("FAIL reset_sat_bin: got %0d want 0", sif.bin); end
    endtask

    task automatic test_up_count();
        logic [3:0] g_exp [16] = '{4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4, 4'd12,
                                   4'd13, 4'd15, 4'd14, 4'd10, 4'd11, 4'd9, 4'd8, 4'd0};
        logic [3:0] b_exp;
        rst = 1'b0; en = 1'b1; up = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            b_exp = 4'(i + 1);
            tests++; if (wif.bin !== b_exp) begin fails++; $display("FAIL up_bin[%0d]: got %0d want %0d", i, wif.bin, b_exp); end
            tests++; if (wif.gray !== g_exp[i]) begin fails++; $display("FAIL up_gray[%0d]: got %0d want %0d", i, wif.gray, g_exp[i]); end
            tests++; if (wif.tc !== (i == 15)) begin fails++; $display("FAIL up_tc[%0d]: got %0b want %0b", i, wif.tc, i == 15); end
        end
        en = 1'b0;
    endtask

    task automatic test_down_wrap();
        load = 1'b1; load_bin = 4'd0; en = 1'b0;
        tick();
        load = 1'b0; en = 1'b1; up = 1'b0;
        tick();
        tests++; if (wif.bin !== 4'd15) begin fails++; $display("FAIL down_wrap_bin: got %0d want 15", wif.bin); end
        tests++; if (wif.gray !== 4'd8) begin fails++; $display("FAIL down_wrap_gray: got %0d want 8", wif.gray); end
        tests++; if (wif.tc !== 1'b1) begin fails++; $display("FAIL down_wrap_tc: got %0b want 1", wif.tc); end
        tests++; if (sif.bin !== 4'd0) begin fails++; $display("FAIL down_sat_bin: got %0d want 0", sif.bin); end
        tests++; if (sif.tc !== 1'b1) begin fails++; $display("FAIL down_sat_tc: got %0b want 1", sif.tc); end
        tick();
        tests++; if (wif.bin !== 4'd14) begin fails++; $display("FAIL down_next_bin: got %0d want 14", wif.bin); end
        tests++; if (wif.gray !== 4'd9) begin fails++; $display("FAIL down_next_gray: got %0d want 9", wif.gray); end
        tests++; if (wif.tc !== 1'b0) begin fails++; $display("FAIL down_next_tc: got %0b want 0", wif.tc); end
        en = 1'b0;
    endtask

    task automatic test_saturate();
        logic tc_exp [3] = '{1'b0, 1'b1, 1'b1};
        load = 1'b1; load_bin = 4'd14; en = 1'b0;
        tick();
        load = 1'b0; en = 1'b1; up = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++; if (sif.bin !== 4'd15) begin fails++; $display("FAIL sat_bin[%0d]: got %0d want 15", i, sif.bin); end
            tests++; if (sif.gray !== 4'd8) begin fails++; $display("FAIL sat_gray[%0d]: got %0d want 8", i, sif.gray); end
            tests++; if (sif.tc !== tc_exp[i]) begin fails++; $display("FAIL sat_tc[%0d]: got %0b want %0b", i, sif.tc, tc_exp[i]); end
        end
        up = 1'b0;
        tick();
        tests++; if (sif.bin !== 4'd14) begin fails++; $display("FAIL sat_reverse_bin: got %0d want 14", sif.bin); end
        tests++; if (sif.tc !== 1'b0) begin fails++; $display("FAIL sat_reverse_tc: got %0b want 0", sif.tc); end
        en = 1'b0;
        tick();
        tests++; if (sif.bin !== 4'd14) begin fails++; $display("FAIL hold_bin: got %0d want 14", sif.bin); end
        tests++; if (sif.gray !== 4'd9) begin fails++; $display("FAIL hold_gray: got %0d want 9", sif.gray); end
    endtask

    task automatic test_load_priority();
        load = 1'b1; load_bin = 4'd9; en = 1'b1; up = 1'b1;
        tick();
        tests++; if (wif.bin !== 4'd9) begin fails++; $display("FAIL load_bin: got %0d want 9", wif.bin); end
        tests++; if (wif.gray !== 4'd13) begin fails++; $display("FAIL load_gray: got %0d want 13", wif.gray); end
        tests++; if (wif.tc !== 1'b0) begin fails++; $display("FAIL load_tc: got %0b want 0", wif.tc); end
        load = 1'b1; load_bin = 4'd15; en = 1'b1; up = 1'b1;
        tick();
        tests++; if (wif.tc !== 1'b0) begin fails++; $display("FAIL load_at_max_tc: got %0b want 0", wif.tc); end
        load = 1'b0; en = 1'b0;
    endtask

    task automatic test_reset_mid();
        rst = 1'b1;
        tick();
        rst = 1'b0; en = 1'b1; up = 1'b1;
        repeat (6) tick();
        tests++; if (wif.bin !== 4'd6) begin fails++; $display("FAIL mid_count_bin: got %0d want 6", wif.bin); end
        tests++; if (wif.gray !== 4'd5) begin fails++; $display("FAIL mid_count_gray: got %0d want 5", wif.gray); end
        rst = 1'b1; load = 1'b1; load_bin = 4'd11;
        tick();
        tests++; if (wif.bin !== 4'd0) begin fails++; $display("FAIL mid_rst_bin: got %0d want 0", wif.bin); end
        tests++; if (wif.gray !== 4'd0) begin fails++; $display("FAIL mid_rst_gray: got %0d want 0", wif.gray); end
        tests++; if (wif.tc !== 1'b0) begin fails++; $display("FAIL mid_rst_tc: got %0b want 0", wif.tc); end
        rst = 1'b0; load = 1'b0; en = 1'b0;
    endtask

    task automatic test_random();
        logic [3:0] mw, ms, pgw, pgs;
        logic tw, ts;
        load = 1'b1; load_bin = 4'd0; en = 1'b0;
        tick();
        mw = 4'd0; ms = 4'd0;
        for (int i = 0; i < 1000; i++) begin
            pgw = wif.gray; pgs = sif.gray;
            en = 1'($urandom_range(0, 3) != 0);
            up = 1'($urandom_range(0, 1));
            load = 1'($urandom_range(0, 19) == 0);
            load_bin = 4'($urandom_range(0, 15));
            tw = 1'b0; ts = 1'b0;
            if (load) begin
                mw = load_bin; ms = load_bin;
            end else if (en) begin
                if (up) begin
                    tw = (mw == 4'd15); ts = (ms == 4'd15);
                    mw = mw + 4'd1;
                    ms = ts ? ms : ms + 4'd1;
                end else begin
                    tw = (mw == 4'd0); ts = (ms == 4'd0);
                    mw = mw - 4'd1;
                    ms = ts ? ms : ms - 4'd1;
                end
            end
            tick();
            tests++; if (wif.bin !== mw || wif.tc !== tw) begin fails++; $display("FAIL rand_wrap[%0d]: got bin %0d tc %0b want bin %0d tc %0b", i, wif.bin, wif.tc, mw, tw); end
            tests++; if (sif.bin !== ms || sif.tc !== ts) begin fails++; $display("FAIL rand_sat[%0d]: got bin %0d tc %0b want bin %0d tc %0b", i, sif.bin, sif.tc, ms, ts); end
            tests++; if (wif.gray !== (mw ^ (mw >> 1)) || sif.gray !== (ms ^ (ms >> 1))) begin fails++; $display("FAIL rand_gray[%0d]: got %0d/%0d want %0d/%0d", i, wif.gray, sif.gray, mw ^ (mw >> 1), ms ^ (ms >> 1)); end
            if (en && !load) begin
                tests++; if ($countones(wif.gray ^ pgw) != 1) begin fails++; $display("FAIL rand_wrap_onebit[%0d]: got %0d->%0d want one bit change", i, pgw, wif.gray); end
                if (!ts) begin
                    tests++; if ($countones(sif.gray ^ pgs) != 1) begin fails++; $display("FAIL rand_sat_onebit[%0d]: got %0d->%0d want one bit change", i, pgs, sif.gray); end
                end
            end
        end
        en = 1'b0; load = 1'b0;
    endtask

    initial begin
        test_reset();
        test_up_count();
        test_down_wrap();
        test_saturate();
        test_load_priority();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
